aes_blok_toplayici: RTL and testbench
=====================================

Name: aes_blok_toplayici

Overview:
Upstream feeder for aes_engine. Collects a byte stream (e.g. from UART RX) into 128-bit blocks. Hands each block to the engine with a one-cycle g_gecerli pulse, paced by the engine's hazir. A collector register plus a holding register let the next block be gathered while the engine is busy. A flush strobe pads and emits a partial final block.

Parameters:
BAYT_SAYISI, 16, bytes per block; only 16 is supported (AES block), kept for the width derivation.
SAYAC_W, 16, width of the emitted-block counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
g_bayt  input  8  input byte
g_bayt_gecerli  input  1  input byte valid
g_bayt_hazir  output  1  block can accept a byte this cycle
bitir  input  1  flush strobe; end of message
motor_hazir  input  1  aes_engine hazir (level)
blok  output  128  block to aes_engine blok; first byte in [127:120]
blok_gecerli  output  1  one-cycle pulse to aes_engine g_gecerli
blok_sayisi  output  SAYAC_W  blocks emitted since reset; wraps modulo 2^SAYAC_W

Behaviour:
- Clocking and reset: all state is updated on posedge clk. Reset is synchronous and active-high. Reset overrides all other inputs, including mid-block.
- Reset values: g_bayt_hazir=1, blok=0, blok_gecerli=0, blok_sayisi=0, collector count=0, holding empty, dolgu_bekliyor=0, arm=1.
- Byte accept: a byte is accepted when g_bayt_gecerli and g_bayt_hazir are both high at the edge. The byte is written at position count, into bits [127-8*count -: 8]; count then increments.
- g_bayt_hazir: equals !(count==16 || dolgu_bekliyor). It is a combinational function of registered state only.
- Load to holding: when count==16 and holding is empty and blok_gecerli==0, the collector moves into holding at the edge and count returns to 0.
- Direct load: a 16th byte arriving while holding is empty loads holding at that same edge; count returns to 0.
- Holding stability: the holding register drives blok and stays stable from load until after the blok_gecerli cycle.
- Emit: at an edge where holding is full, motor_hazir==1 and arm==1:
  - blok_gecerli is set to 1 for exactly one cycle;
  - holding is marked empty;
  - arm is cleared;
  - blok_sayisi increments.
- Re-arm: arm is set again at any edge where motor_hazir==0. This prevents a double pulse before the engine drops hazir.
- Emit latency: the 16th byte is accepted at edge N. With motor_hazir=1 and arm=1, blok_gecerli is high in the cycle after edge N+1.
- Flush (bitir):
  - bitir is honoured only when g_bayt_hazir==1; otherwise it is ignored.
  - A byte accepted in the same cycle is included as the last byte before padding.
  - When 0 < count' < 16 (count' = count after the same-cycle byte), bytes count'..15 are filled with the pad value and count becomes 16.
  - Pad value: 0x00 without the macro; 16-count' with it.
- FSM for the collector, states TOPLA / DOLU / DOLGU:
  - TOPLA -> DOLU when count reaches 16.
  - DOLU -> TOPLA when moved to holding.
  - Any state -> DOLGU when dolgu_bekliyor is set.
  - DOLGU -> DOLU when the full pad block is generated.
- Simultaneous events: a holding-empty transition at the same edge as the collector filling is allowed only if blok_gecerli was 0 in that cycle. Otherwise the load is delayed one cycle.

Optional Feature:
AES_PKCS7_DOLGU_EN
- Defined: PKCS#7 padding.
  - Partial block: pad byte = 16-count'.
  - bitir with count'==0 or count'==16: dolgu_bekliyor is set and an extra block of sixteen 0x10 is emitted after any pending block.
- Undefined: zero padding. bitir with count'==0 or count'==16 has no effect, and dolgu_bekliyor is constantly 0.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLOK_BAYT=16;
  - AES_BLOK_W=128;
  - collector state typedef (TOPLA, DOLU, DOLGU);
  - PKCS7 full-pad constant {16{8'h10}}.
- Sub-module blok_dolgu_uret: combinational; inputs are partial block and count'; output is the padded block. It contains the only macro-dependent logic.

Test Plan:
1. Stream bytes "qwertyuiopasdfgh" (0x71..0x68) with motor_hazir=1 -> one blok_gecerli pulse; blok = 0x71776572747975696f70617364666768; blok_sayisi=1.
2. Send 32 bytes while motor_hazir=0 -> after 32 accepts, g_bayt_hazir=0. Raise motor_hazir -> first block pulses. Drop and raise motor_hazir -> second block pulses. g_bayt_hazir returns to 1.
3. Send 5 bytes 0x01..0x05 then bitir:
   - macro undefined -> blok = 0x0102030405 followed by 11 bytes 0x00;
   - macro defined -> 11 bytes 0x0B.
4. With AES_PKCS7_DOLGU_EN, send 16 bytes with bitir on the 16th -> data block emitted, then a block 0x10101010101010101010101010101010; blok_sayisi=2.
5. Assert rst after byte 7 of a block -> next edge: count=0, blok_gecerli=0, blok_sayisi=0. The following 16 bytes form a clean block with no residue of the earlier 7 bytes.
6. Hold motor_hazir=1 continuously across two full blocks -> exactly one pulse, no second pulse until motor_hazir goes low for at least one cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES block feeder.
// The optional PKCS#7 padding is selected with AES_PKCS7_DOLGU_EN.
package aes_pkg;

   localparam int AES_BLOK_BAYT = 16;
   localparam int AES_BLOK_W    = 128;

   typedef enum logic [1:0] {
      TOPLA = 2'd0,
      DOLU  = 2'd1,
      DOLGU = 2'd2
   } topla_durum_t;

   localparam logic [AES_BLOK_W-1:0] PKCS7_TAM_DOLGU = {16{8'h10}};

endpackage

// File: rtl/blok_dolgu_uret.sv
// Pads a partial block from byte position i_sayi onward.
// AES_PKCS7_DOLGU_EN selects PKCS#7 padding; otherwise zero padding is used.
module blok_dolgu_uret
   import aes_pkg::*;
(
   input  logic [AES_BLOK_W-1:0] i_blok,
   input  logic [4:0]            i_sayi,
   output logic [AES_BLOK_W-1:0] o_blok,
   output logic                  o_ek_blok
);

   logic [7:0] w_dolgu;

`ifdef AES_PKCS7_DOLGU_EN
   assign w_dolgu   = 8'(AES_BLOK_BAYT) - {3'b000, i_sayi};
   // An empty or exactly full message still needs a whole block of padding.
   assign o_ek_blok = (i_sayi == 5'd0) || (i_sayi == 5'(AES_BLOK_BAYT));
`else
   assign w_dolgu   = 8'h00;
   assign o_ek_blok = 1'b0;
`endif

   // NOTE: the default assignment before the loop keeps this block free of latches.
   always_comb begin
      o_blok = i_blok;
      for (int i = 0; i < AES_BLOK_BAYT; i++) begin
         if (5'(i) >= i_sayi) o_blok[AES_BLOK_W-1-8*i -: 8] = w_dolgu;
      end
   end

endmodule

// File: rtl/aes_blok_toplayici.sv
// Gathers a byte stream into 128-bit blocks and hands them to aes_engine.
// AES_PKCS7_DOLGU_EN enables PKCS#7 padding (including the extra full pad block).
module aes_blok_toplayici
   import aes_pkg::*;
#(
   parameter int BAYT_SAYISI = 16,
   parameter int SAYAC_W     = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               g_bayt,
   input  logic                     g_bayt_gecerli,
   output logic                     g_bayt_hazir,
   input  logic                     bitir,
   input  logic                     motor_hazir,
   output logic [8*BAYT_SAYISI-1:0] blok,
   output logic                     blok_gecerli,
   output logic [SAYAC_W-1:0]       blok_sayisi
);

   localparam int                BLOK_W = 8 * BAYT_SAYISI;
   localparam int                SAYI_W = $clog2(BAYT_SAYISI + 1);
   localparam logic [SAYI_W-1:0] TAM    = SAYI_W'(BAYT_SAYISI);

   logic [BLOK_W-1:0]  r_topla;
   logic [SAYI_W-1:0]  r_sayi;
   logic [BLOK_W-1:0]  r_tut;
   logic               r_tut_dolu;
   logic               r_gecerli;
   logic [SAYAC_W-1:0] r_sayac;
   logic               r_arm;
   logic               r_dolgu_bekliyor;
   topla_durum_t       r_durum;

   logic               w_kabul;
   logic               w_bitir;
   logic [BLOK_W-1:0]  w_topla_b;
   logic [SAYI_W-1:0]  w_sayi_b;
   logic [BLOK_W-1:0]  w_dolgulu;
   logic               w_ek_blok;
   logic               w_kismi_dolgu;
   logic               w_ek_dolgu;
   logic               w_yer;
   logic               w_tasi;
   logic               w_tam_dolgu;

   assign g_bayt_hazir = !(r_sayi == TAM || r_dolgu_bekliyor);
   assign w_kabul      = g_bayt_gecerli && g_bayt_hazir;
   assign w_bitir      = bitir && g_bayt_hazir;
   assign w_sayi_b     = r_sayi + SAYI_W'(w_kabul);

   always_comb begin
      w_topla_b = r_topla;
      for (int i = 0; i < BAYT_SAYISI; i++) begin
         if (w_kabul && r_sayi == SAYI_W'(i)) w_topla_b[BLOK_W-1-8*i -: 8] = g_bayt;
      end
   end

   blok_dolgu_uret u_dolgu (
      .i_blok    (w_topla_b),
      .i_sayi    (w_sayi_b),
      .o_blok    (w_dolgulu),
      .o_ek_blok (w_ek_blok)
   );

   assign w_kismi_dolgu = w_bitir && (w_sayi_b != '0) && (w_sayi_b != TAM);
   assign w_ek_dolgu    = w_bitir && w_ek_blok;
   // Holding may only be refilled once the previous block's pulse cycle is over.
   assign w_yer         = !r_tut_dolu && !r_gecerli;
   assign w_tasi        = (w_sayi_b == TAM) && w_yer;
   assign w_tam_dolgu   = r_dolgu_bekliyor && (r_sayi == '0);

   // NOTE: reset is synchronous and clears the data registers too, so blok reads 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_topla          <= '0;
         r_sayi           <= '0;
         r_tut            <= '0;
         r_tut_dolu       <= 1'b0;
         r_gecerli        <= 1'b0;
         r_sayac          <= '0;
         r_arm            <= 1'b1;
         r_dolgu_bekliyor <= 1'b0;
         r_durum          <= TOPLA;
      end else begin
         // NOTE: the pulse defaults low every cycle so it lasts exactly one cycle.
         r_gecerli <= 1'b0;
         if (!motor_hazir) r_arm <= 1'b1;

         if (r_tut_dolu && motor_hazir && r_arm) begin
            r_gecerli  <= 1'b1;
            r_tut_dolu <= 1'b0;
            r_arm      <= 1'b0;
            r_sayac    <= r_sayac + SAYAC_W'(1);
         end

         if (w_tasi) begin
            r_tut      <= w_topla_b;
            r_tut_dolu <= 1'b1;
            r_sayi     <= '0;
         end else if (w_kismi_dolgu) begin
            r_topla <= w_dolgulu;
            r_sayi  <= TAM;
         end else if (w_tam_dolgu) begin
            r_topla          <= PKCS7_TAM_DOLGU;
            r_sayi           <= TAM;
            r_dolgu_bekliyor <= 1'b0;
         end else begin
            r_topla <= w_topla_b;
            r_sayi  <= w_sayi_b;
         end

         if (w_ek_dolgu) r_dolgu_bekliyor <= 1'b1;

         if (w_ek_dolgu) begin
            r_durum <= DOLGU;
         end else begin
            case (r_durum)
               TOPLA:   if ((w_sayi_b == TAM && !w_yer) || w_kismi_dolgu) r_durum <= DOLU;
               DOLU:    if (w_yer) r_durum <= TOPLA;
               DOLGU:   if (w_tam_dolgu) r_durum <= DOLU;
               default: r_durum <= TOPLA;
            endcase
         end
      end
   end

   assign blok         = r_tut;
   assign blok_gecerli = r_gecerli;
   assign blok_sayisi  = r_sayac;

endmodule

// File: tb/tb_aes_blok_toplayici.sv
// Scoreboard bench for aes_blok_toplayici: a byte-list model queues expected blocks,
// a monitor pops and compares them on every blok_gecerli pulse.
module tb_aes_blok_toplayici;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   g_bayt;
   logic         g_bayt_gecerli;
   logic         g_bayt_hazir;
   logic         bitir;
   logic         motor_hazir;
   logic [127:0] blok;
   logic         blok_gecerli;
   logic [15:0]  blok_sayisi;

   always #5 clk = ~clk;

   aes_blok_toplayici #(.BAYT_SAYISI(16), .SAYAC_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .g_bayt         (g_bayt),
      .g_bayt_gecerli (g_bayt_gecerli),
      .g_bayt_hazir   (g_bayt_hazir),
      .bitir          (bitir),
      .motor_hazir    (motor_hazir),
      .blok           (blok),
      .blok_gecerli   (blok_gecerli),
      .blok_sayisi    (blok_sayisi)
   );

   int           n_checks = 0;
   int           n_errors = 0;
   int           n_pulse  = 0;
   logic [15:0]  exp_sayi = 16'd0;
   logic [127:0] exp_q[$];
   logic [7:0]   cur[$];
   bit           rnd_on;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain list of accepted bytes, cut into 16-byte blocks.
   task automatic push_block();
      logic [127:0] v = '0;
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = cur[i];
      exp_q.push_back(v);
      cur.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      cur.push_back(b);
      if (cur.size() == 16) push_block();
   endtask

   task automatic model_flush();
      int n = cur.size();
      logic [7:0] pad;
`ifdef AES_PKCS7_DOLGU_EN
      pad = 8'(16 - n);
`else
      pad = 8'h00;
`endif
      if (n > 0) begin
         while (cur.size() < 16) cur.push_back(pad);
         push_block();
      end
`ifdef AES_PKCS7_DOLGU_EN
      else begin
         for (int i = 0; i < 16; i++) cur.push_back(8'h10);
         push_block();
      end
`endif
   endtask

   always @(negedge clk) begin
      if (!rst && blok_gecerli) begin
         n_pulse++;
         exp_sayi++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pulse: blok %h while no block was expected", blok);
         end else begin
            check("blok", blok, exp_q.pop_front());
         end
         check("blok_sayisi", 128'(blok_sayisi), 128'(exp_sayi));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] b, input logic vld, input logic fl);
      int t = 0;
      g_bayt = b; g_bayt_gecerli = vld; bitir = fl;
      while (!g_bayt_hazir && t < 500) begin
         tick();
         t++;
      end
      if (!g_bayt_hazir) begin
         check("hazir_timeout", 128'(g_bayt_hazir), 128'd1);
      end else begin
         if (vld) model_byte(b);
         if (fl) model_flush();
      end
      tick();
      g_bayt_gecerli = 1'b0; bitir = 1'b0;
   endtask

   task automatic wait_pulse(input int target);
      int t = 0;
      while (n_pulse < target && t < 60) begin
         tick();
         t++;
      end
      check("pulse_arrived", 128'(n_pulse >= target), 128'd1);
   endtask

   task automatic rearm();
      motor_hazir = 1'b0;
      tick();
      motor_hazir = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      string s = "qwertyuiopasdfgh";
      int base;
      logic [15:0] sayi0;

      rst = 1'b1; g_bayt = 8'h00; g_bayt_gecerli = 1'b0; bitir = 1'b0; motor_hazir = 1'b0;
      tick(); tick();
      check("rst_hazir", 128'(g_bayt_hazir), 128'd1);
      check("rst_blok", blok, 128'd0);
      check("rst_gecerli", 128'(blok_gecerli), 128'd0);
      check("rst_sayisi", 128'(blok_sayisi), 128'd0);
      rst = 1'b0;

      // 1: single block with engine ready, plus emit latency
      motor_hazir = 1'b1;
      for (int i = 0; i < 16; i++) drive(s[i], 1'b1, 1'b0);
      check("t1_gecerli_n1", 128'(blok_gecerli), 128'd0);
      tick();
      check("t1_gecerli_n2", 128'(blok_gecerli), 128'd1);
      check("t1_blok", blok, 128'h71776572747975696f70617364666768);
      check("t1_sayisi", 128'(blok_sayisi), 128'd1);

      // 2: two blocks while the engine is busy
      motor_hazir = 1'b0;
      tick();
      base = n_pulse;
      for (int i = 0; i < 32; i++) drive(8'($urandom), 1'b1, 1'b0);
      check("t2_hazir_full", 128'(g_bayt_hazir), 128'd0);
      tick(); tick(); tick();
      check("t2_no_pulse", 128'(n_pulse), 128'(base));
      motor_hazir = 1'b1;
      wait_pulse(base + 1);
      for (int i = 0; i < 5; i++) tick();
      check("t2_single_pulse", 128'(n_pulse), 128'(base + 1));
      rearm();
      wait_pulse(base + 2);
      tick();
      check("t2_hazir_back", 128'(g_bayt_hazir), 128'd1);

      // 3: partial block then flush
      rearm();
      base = n_pulse;
      for (int i = 1; i <= 5; i++) drive(8'(i), 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b1);
      wait_pulse(base + 1);
`ifdef AES_PKCS7_DOLGU_EN
      check("t3_pad", blok, 128'h01020304050B0B0B0B0B0B0B0B0B0B0B);
`else
      check("t3_pad", blok, 128'h01020304050000000000000000000000);
`endif

`ifdef AES_PKCS7_DOLGU_EN
      // 4: full block with flush on the last byte -> extra pad block
      rearm();
      base = n_pulse;
      sayi0 = blok_sayisi;
      for (int i = 0; i < 16; i++) drive(8'($urandom), 1'b1, i == 15);
      wait_pulse(base + 1);
      rearm();
      wait_pulse(base + 2);
      check("t4_pad_block", blok, {16{8'h10}});
      check("t4_sayisi", 128'(blok_sayisi - sayi0), 128'd2);
`endif

      // 5: reset in the middle of a block
      rearm();
      for (int i = 0; i < 7; i++) drive(8'($urandom), 1'b1, 1'b0);
      rst = 1'b1;
      cur.delete();
      exp_q.delete();
      exp_sayi = 16'd0;
      tick();
      check("t5_gecerli", 128'(blok_gecerli), 128'd0);
      check("t5_sayisi", 128'(blok_sayisi), 128'd0);
      check("t5_hazir", 128'(g_bayt_hazir), 128'd1);
      check("t5_blok", blok, 128'd0);
      rst = 1'b0;
      base = n_pulse;
      for (int i = 0; i < 16; i++) drive(8'($urandom), 1'b1, 1'b0);
      wait_pulse(base + 1);

      // 6: engine ready held high across two blocks
      rearm();
      base = n_pulse;
      for (int i = 0; i < 32; i++) drive(8'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) tick();
      check("t6_one_pulse", 128'(n_pulse), 128'(base + 1));
      rearm();
      wait_pulse(base + 2);

      // Random traffic with a randomly toggling engine
      rnd_on = 1'b1;
      fork
         while (rnd_on) begin
            motor_hazir = 1'($urandom_range(0, 1));
            tick();
         end
      join_none
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         if ($urandom_range(0, 24) == 0) drive(8'h00, 1'b0, 1'b1);
         else drive(8'($urandom), 1'b1, $urandom_range(0, 19) == 0);
      end
      rnd_on = 1'b0;
      tick(); tick();
      for (int t = 0; t < 200 && exp_q.size() > 0; t++) begin
         rearm();
         tick(); tick();
      end
      tick(); tick(); tick();
      check("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
